// File: rtl/decodificador_servo_3.sv
// rtl/decodificador_servo_3.sv - servo PWM receiver: measures pulse high time and decodes the 3-bit position
//
// Purpose: receive side of the 3-bit servo position link. Measures the high
// time of a 50 Hz servo PWM input and maps it back to a position code, flagging
// out-of-range pulses and loss of signal.
//
// Ports:
//   clock          in   system clock
//   reset          in   asynchronous, active-high reset
//   pwm            in   asynchronous servo PWM input
//   posicao        out  last decoded position code
//   valido         out  last pulse in range and no timeout since
//   erro           out  out-of-range pulse or timeout; cleared by the next good pulse
//   largura_medida out  high time of the last completed pulse, in cycles
//   db_pwm         out  synchronized pwm
//   db_estado      out  FSM state code
module decodificador_servo_3 #(
  parameter int conf_periodo = 1000000,
  parameter int timeout      = 2000000,
  parameter int largura_000  = 35000,
  parameter int largura_001  = 45700,
  parameter int largura_010  = 56450,
  parameter int largura_011  = 67150,
  parameter int largura_100  = 77850,
  parameter int largura_101  = 88550,
  parameter int largura_110  = 99300,
  parameter int largura_111  = 110000,
  parameter int tolerancia   = 5000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pwm,
  output logic [2:0]  posicao,
  output logic        valido,
  output logic        erro,
  output logic [20:0] largura_medida,
  output logic        db_pwm,
  output logic [1:0]  db_estado
);

  localparam logic [20:0] cnt_max        = '1;
  localparam logic [20:0] limite_timeout = 21'(timeout);

  // Decision points halfway between neighbouring nominal widths.
  localparam logic [20:0] limiar_0 = 21'((largura_000 + largura_001) / 2);
  localparam logic [20:0] limiar_1 = 21'((largura_001 + largura_010) / 2);
  localparam logic [20:0] limiar_2 = 21'((largura_010 + largura_011) / 2);
  localparam logic [20:0] limiar_3 = 21'((largura_011 + largura_100) / 2);
  localparam logic [20:0] limiar_4 = 21'((largura_100 + largura_101) / 2);
  localparam logic [20:0] limiar_5 = 21'((largura_101 + largura_110) / 2);
  localparam logic [20:0] limiar_6 = 21'((largura_110 + largura_111) / 2);

  localparam logic [20:0] faixa_min = 21'(largura_000 - tolerancia);
  localparam logic [20:0] faixa_max = 21'(largura_111 + tolerancia);

  // The threshold decode assumes strictly increasing widths, and a timeout
  // shorter than the nominal period would flag every healthy signal as lost.
  if (!(largura_000 < largura_001 && largura_001 < largura_010 &&
        largura_010 < largura_011 && largura_011 < largura_100 &&
        largura_100 < largura_101 && largura_101 < largura_110 &&
        largura_110 < largura_111) || (timeout <= conf_periodo)) begin : g_config_invalida
    $error("decodificador_servo_3: widths must increase and timeout must exceed the period");
  end

  typedef enum logic [1:0] {
    espera_subida = 2'b00,
    mede_alto     = 2'b01,
    mede_baixo    = 2'b10
  } estado_t;

  estado_t     estado, estado_prox;
  logic        pwm_meta, pwm_sinc, pwm_ant;
  logic [1:0]  pronto;
  logic        subida, descida, estourou;
  logic        registra, perdeu;
  logic [20:0] cnt_alto, cnt_periodo;
  logic [2:0]  codigo;
  logic        em_faixa;

  // Synchronizer plus previous-value register. pwm_ant is frozen at 1 until
  // the synchronizer has been refilled after reset; otherwise the zeros left
  // in the chain by reset would make a line already high look like a fresh
  // rising edge, and a pulse in progress at reset release would be measured.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pwm_meta <= 1'b0;
      pwm_sinc <= 1'b0;
      pwm_ant  <= 1'b1;
      pronto   <= 2'b00;
    end else begin
      pwm_meta <= pwm;
      pwm_sinc <= pwm_meta;
      pronto   <= {pronto[0], 1'b1};
      if (pronto[1]) begin
        pwm_ant <= pwm_sinc;
      end
    end
  end

  assign subida   = pronto[1] &  pwm_sinc & ~pwm_ant;
  assign descida  = pronto[1] & ~pwm_sinc &  pwm_ant;
  assign estourou = (cnt_periodo == limite_timeout);

  // Both counters restart at 1 on a rising edge so the rising-edge cycle
  // itself is counted; they saturate instead of wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_alto    <= '0;
      cnt_periodo <= '0;
    end else begin
      if (subida) begin
        cnt_alto <= 21'd1;
      end else if (pwm_sinc && cnt_alto != cnt_max) begin
        cnt_alto <= cnt_alto + 21'd1;
      end

      if (subida) begin
        cnt_periodo <= 21'd1;
      end else if (cnt_periodo != cnt_max) begin
        cnt_periodo <= cnt_periodo + 21'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado <= espera_subida;
    end else begin
      estado <= estado_prox;
    end
  end

  // A timeout wins over an edge seen in the same cycle.
  always_comb begin
    estado_prox = estado;
    case (estado)
      espera_subida: if (subida) estado_prox = mede_alto;
      mede_alto: begin
        if (estourou)     estado_prox = espera_subida;
        else if (descida) estado_prox = mede_baixo;
      end
      mede_baixo: begin
        if (estourou)     estado_prox = espera_subida;
        else if (subida)  estado_prox = mede_alto;
      end
      default: estado_prox = espera_subida;
    endcase
  end

  always_comb begin
    registra = 1'b0;
    perdeu   = 1'b0;
    case (estado)
      mede_alto: begin
        perdeu   = estourou;
        registra = descida & ~estourou;
      end
      mede_baixo: perdeu = estourou;
      default: begin
        registra = 1'b0;
        perdeu   = 1'b0;
      end
    endcase
  end

  // Code = number of thresholds the width has reached.
  always_comb begin
    codigo = 3'd0;
    if (cnt_alto >= limiar_0) codigo = 3'd1;
    if (cnt_alto >= limiar_1) codigo = 3'd2;
    if (cnt_alto >= limiar_2) codigo = 3'd3;
    if (cnt_alto >= limiar_3) codigo = 3'd4;
    if (cnt_alto >= limiar_4) codigo = 3'd5;
    if (cnt_alto >= limiar_5) codigo = 3'd6;
    if (cnt_alto >= limiar_6) codigo = 3'd7;
  end

  assign em_faixa = (cnt_alto >= faixa_min) && (cnt_alto <= faixa_max);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      posicao        <= 3'd0;
      valido         <= 1'b0;
      erro           <= 1'b0;
      largura_medida <= '0;
    end else if (registra) begin
      largura_medida <= cnt_alto;
      if (em_faixa) begin
        posicao <= codigo;
        valido  <= 1'b1;
        erro    <= 1'b0;
      end else begin
        valido  <= 1'b0;
        erro    <= 1'b1;
      end
    end else if (perdeu) begin
      valido <= 1'b0;
      erro   <= 1'b1;
    end
  end

  assign db_pwm    = pwm_sinc;
  assign db_estado = estado;

endmodule

// File: tb/tb_decodificador_servo_3.sv
// tb/tb_decodificador_servo_3.sv - scoreboard bench for the servo PWM decoder
module tb_decodificador_servo_3;

  localparam int T   = 200;
  localparam int TOL = 5;
  localparam int L0 = 35, L1 = 46, L2 = 56, L3 = 67, L4 = 78, L5 = 89, L6 = 99, L7 = 110;

  typedef struct {
    int       cyc;
    bit       tmo;
    logic [2:0] pos;
    bit       val;
    bit       err;
    int       larg;
    bit       lvl;
  } evento_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pwm   = 1'b0;
  logic [2:0]  posicao;
  logic        valido;
  logic        erro;
  logic [20:0] largura_medida;
  logic        db_pwm;
  logic [1:0]  db_estado;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int larg_tab[8];
  evento_t esperado[$];
  logic [2:0] m_pos = 3'd0;
  int m_larg = 0;
  logic [1:0] est_ant = 2'b00;

  decodificador_servo_3 #(
    .conf_periodo(100), .timeout(T),
    .largura_000(L0), .largura_001(L1), .largura_010(L2), .largura_011(L3),
    .largura_100(L4), .largura_101(L5), .largura_110(L6), .largura_111(L7),
    .tolerancia(TOL)
  ) dut (
    .clock(clock), .reset(reset), .pwm(pwm),
    .posicao(posicao), .valido(valido), .erro(erro),
    .largura_medida(largura_medida), .db_pwm(db_pwm), .db_estado(db_estado)
  );

  always #10 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Reference decode: in range if within tolerance of the extreme widths;
  // the code is how many midpoints between neighbouring widths are reached.
  function automatic void modelo(input int w, output bit ok, output logic [2:0] cod);
    ok  = (w >= larg_tab[0] - TOL) && (w <= larg_tab[7] + TOL);
    cod = 3'd0;
    for (int k = 0; k < 7; k++) begin
      if (w >= (larg_tab[k] + larg_tab[k+1]) / 2) cod = cod + 3'd1;
    end
  endfunction

  task automatic espera(input int c, input bit t, input logic [2:0] p, input bit v,
                        input bit e, input int l, input bit n);
    evento_t ev;
    ev.cyc = c; ev.tmo = t; ev.pos = p; ev.val = v; ev.err = e; ev.larg = l; ev.lvl = n;
    esperado.push_back(ev);
  endtask

  task automatic chk(input string nome, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nome, got, want);
    end
  endtask

  // One pulse: high for w input cycles, then low for l cycles before the next rise.
  task automatic pulso(input int w, input int l);
    int r;
    bit ok;
    logic [2:0] cod;
    @(posedge clock); #1;
    r = cyc;
    pwm = 1'b1;
    if (w > T) begin
      espera(r + T + 3, 1'b1, m_pos, 1'b0, 1'b1, m_larg, 1'b1);
    end else begin
      modelo(w, ok, cod);
      m_larg = w;
      if (ok) m_pos = cod;
      espera(r + w + 3, 1'b0, m_pos, ok, !ok, w, 1'b0);
      if (w + l > T) espera(r + T + 3, 1'b1, m_pos, 1'b0, 1'b1, w, 1'b0);
    end
    repeat (w) @(posedge clock);
    #1 pwm = 1'b0;
    repeat (l - 1) @(posedge clock);
  endtask

  task automatic esvazia(input int limite);
    int n;
    evento_t ev;
    n = 0;
    while (esperado.size() != 0 && n < limite) begin
      @(posedge clock);
      n++;
    end
    while (esperado.size() != 0) begin
      ev = esperado.pop_front();
      checks++;
      errors++;
      $display("FAIL evento_ausente: got nothing by cyc %0d, want event at cyc=%0d tmo=%0b", cyc, ev.cyc, ev.tmo);
    end
  endtask

  always @(negedge clock) begin
    evento_t ev;
    if (reset) begin
      est_ant = 2'b00;
    end else begin
      if (db_estado == 2'b11) begin
        checks++;
        errors++;
        $display("FAIL estado_ilegal: got %0d at cyc %0d, want 0..2", db_estado, cyc);
      end else if (db_estado != est_ant && (db_estado == 2'b10 || db_estado == 2'b00)) begin
        checks++;
        if (esperado.size() == 0) begin
          errors++;
          $display("FAIL evento_inesperado: got estado=%0d pos=%0d val=%0b err=%0b larg=%0d at cyc %0d, want none",
                   db_estado, posicao, valido, erro, largura_medida, cyc);
        end else begin
          ev = esperado.pop_front();
          if (cyc != ev.cyc || (db_estado == 2'b00) != ev.tmo || posicao !== ev.pos ||
              valido !== ev.val || erro !== ev.err || int'(largura_medida) != ev.larg ||
              db_pwm !== ev.lvl) begin
            errors++;
            $display("FAIL evento: got cyc=%0d tmo=%0b pos=%0d val=%0b err=%0b larg=%0d pwm=%0b, want cyc=%0d tmo=%0b pos=%0d val=%0b err=%0b larg=%0d pwm=%0b",
                     cyc, db_estado == 2'b00, posicao, valido, erro, largura_medida, db_pwm,
                     ev.cyc, ev.tmo, ev.pos, ev.val, ev.err, ev.larg, ev.lvl);
          end
        end
      end
      est_ant = db_estado;
    end
  end

  initial begin
    int w, l;
    int especiais[21];
    larg_tab = '{L0, L1, L2, L3, L4, L5, L6, L7};
    especiais = '{29, 30, 31, 39, 40, 41, 50, 51, 60, 61, 71, 72, 82, 83, 93, 94, 103, 104, 114, 115, 116};

    repeat (3) @(posedge clock);
    #1;
    chk("reset_posicao", posicao, 0);
    chk("reset_valido", valido, 0);
    chk("reset_erro", erro, 0);
    chk("reset_largura", largura_medida, 0);
    chk("reset_estado", db_estado, 0);
    reset = 1'b0;
    repeat (10) @(posedge clock);

    pulso(35, 100);
    pulso(67, 100);
    pulso(60, 100);
    pulso(61, 100);
    pulso(29, 100);
    pulso(30, 100);
    pulso(115, 60);
    pulso(116, 60);
    pulso(50, 300);
    pulso(89, 60);
    esvazia(400);

    // Reset in the middle of a 99-cycle pulse; the remainder must be ignored.
    @(posedge clock); #1;
    pwm = 1'b1;
    repeat (20) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("rst_pulso_posicao", posicao, 0);
    chk("rst_pulso_valido", valido, 0);
    chk("rst_pulso_erro", erro, 0);
    chk("rst_pulso_largura", largura_medida, 0);
    chk("rst_pulso_estado", db_estado, 0);
    m_pos = 3'd0;
    m_larg = 0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (77) @(posedge clock);
    #1 pwm = 1'b0;
    repeat (49) @(posedge clock);
    pulso(99, 60);
    pulso(T + 30, 40);
    pulso(78, 60);
    esvazia(400);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) w = especiais[$urandom_range(0, 20)];
      else w = $urandom_range(20, 125);
      if ($urandom_range(0, 19) == 0) w = T + $urandom_range(5, 30);
      if ($urandom_range(0, 9) == 0) l = $urandom_range(T, T + 50);
      else l = $urandom_range(5, 70);
      pulso(w, l);
    end
    esvazia(2 * T + 50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
